// File: rtl/atomrvcore_dccm_arbiter.sv
// Round-robin two-port front end for the single-port DCCM.
// Sub-word stores are expanded into a read-modify-write pair.
module atomrvcore_dccm_arbiter #(
  parameter int DATAWIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   p0_req_i,
  input  logic                   p0_we_i,
  input  logic [DATAWIDTH-1:0]   p0_addr_i,
  input  logic [DATAWIDTH-1:0]   p0_wdata_i,
  input  logic [DATAWIDTH/8-1:0] p0_be_i,
  output logic                   p0_gnt_o,
  output logic                   p0_rvalid_o,
  output logic [DATAWIDTH-1:0]   p0_rdata_o,
  input  logic                   p1_req_i,
  input  logic                   p1_we_i,
  input  logic [DATAWIDTH-1:0]   p1_addr_i,
  input  logic [DATAWIDTH-1:0]   p1_wdata_i,
  input  logic [DATAWIDTH/8-1:0] p1_be_i,
  output logic                   p1_gnt_o,
  output logic                   p1_rvalid_o,
  output logic [DATAWIDTH-1:0]   p1_rdata_o,
  output logic [DATAWIDTH-1:0]   dccm_addr_o,
  output logic [DATAWIDTH-1:0]   dccm_wdata_o,
  output logic                   dccm_wr_en_o,
  output logic                   dccm_rd_en_o,
  input  logic [DATAWIDTH-1:0]   dccm_rdata_i
);

  localparam int BW = DATAWIDTH / 8;
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] RMW_WR = 1'b1;

  logic [0:0]           state_q;
  logic                 prio_q;
  logic                 cap_port_q;
  logic [DATAWIDTH-1:0] cap_addr_q;
  logic [DATAWIDTH-1:0] cap_wdata_q;
  logic [DATAWIDTH-1:0] cap_old_q;
  logic [BW-1:0]        cap_be_q;
  logic                 p0_rvalid_q;
  logic                 p1_rvalid_q;
  logic [DATAWIDTH-1:0] p0_rdata_q;
  logic [DATAWIDTH-1:0] p1_rdata_q;

  logic                 idle;
  logic                 rmw;
  logic                 pick1;
  logic                 gnt0;
  logic                 gnt1;
  logic                 any_gnt;
  logic                 sel_we;
  logic [DATAWIDTH-1:0] sel_addr;
  logic [DATAWIDTH-1:0] sel_wdata;
  logic [BW-1:0]        sel_be;
  logic [DATAWIDTH-1:0] word_addr;
  logic                 is_read;
  logic                 full_wr;
  logic                 part_wr;
  logic [DATAWIDTH-1:0] merged;

  // Reset gates the outputs so an in-flight RMW write never lands.
  assign idle  = rst_ni & (state_q == IDLE);
  assign rmw   = rst_ni & (state_q == RMW_WR);
  assign pick1 = p1_req_i & (~p0_req_i | prio_q);
  assign gnt0  = idle & p0_req_i & ~pick1;
  assign gnt1  = idle & pick1;
  assign any_gnt = gnt0 | gnt1;

  assign sel_we    = pick1 ? p1_we_i    : p0_we_i;
  assign sel_addr  = pick1 ? p1_addr_i  : p0_addr_i;
  assign sel_wdata = pick1 ? p1_wdata_i : p0_wdata_i;
  assign sel_be    = pick1 ? p1_be_i    : p0_be_i;
  assign word_addr = {sel_addr[DATAWIDTH-1:2], 2'b00};

  assign is_read = any_gnt & ~sel_we;
  assign full_wr = any_gnt & sel_we & (&sel_be);
  assign part_wr = any_gnt & sel_we & ~(&sel_be) & (|sel_be);

  always_comb begin
    merged = cap_old_q;
    for (int i = 0; i < BW; i++) begin
      if (cap_be_q[i]) merged[8*i +: 8] = cap_wdata_q[8*i +: 8];
    end
  end

  always_comb begin
    dccm_addr_o  = '0;
    dccm_wdata_o = '0;
    dccm_wr_en_o = 1'b0;
    dccm_rd_en_o = 1'b0;
    unique case (1'b1)
      rmw: begin
        dccm_wr_en_o = 1'b1;
        dccm_addr_o  = cap_addr_q;
        dccm_wdata_o = merged;
      end
      is_read, part_wr: begin
        dccm_rd_en_o = 1'b1;
        dccm_addr_o  = word_addr;
      end
      full_wr: begin
        dccm_wr_en_o = 1'b1;
        dccm_addr_o  = word_addr;
        dccm_wdata_o = sel_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      cap_port_q  <= 1'b0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
      cap_old_q   <= '0;
      cap_be_q    <= '0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
    end else begin
      p0_rvalid_q <= (gnt0 & ~part_wr) | (rmw & ~cap_port_q);
      p1_rvalid_q <= (gnt1 & ~part_wr) | (rmw & cap_port_q);
      if (gnt0 & ~sel_we) p0_rdata_q <= dccm_rdata_i;
      if (gnt1 & ~sel_we) p1_rdata_q <= dccm_rdata_i;
      if (any_gnt) prio_q <= gnt0;
      case (state_q)
        IDLE: begin
          if (part_wr) begin
            state_q     <= RMW_WR;
            cap_port_q  <= gnt1;
            cap_addr_q  <= word_addr;
            cap_wdata_q <= sel_wdata;
            cap_be_q    <= sel_be;
            cap_old_q   <= dccm_rdata_i;
          end
        end
        RMW_WR: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign p0_gnt_o    = gnt0;
  assign p1_gnt_o    = gnt1;
  assign p0_rvalid_o = p0_rvalid_q;
  assign p1_rvalid_o = p1_rvalid_q;
  assign p0_rdata_o  = p0_rdata_q;
  assign p1_rdata_o  = p1_rdata_q;

endmodule

// File: tb/tb_atomrvcore_dccm_arbiter.sv
// Directed bench for the DCCM arbiter with a small DCCM model
// and per-port response scoreboards.
module tb_atomrvcore_dccm_arbiter;

  typedef struct {
    logic        rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [3:0]  p0_be, p1_be;
  logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] dccm_addr, dccm_wdata, dccm_rdata;
  logic        dccm_wr_en, dccm_rd_en;

  logic [31:0] mem [0:255];
  exp_t        q0[$];
  exp_t        q1[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign dccm_rdata = mem[dccm_addr[9:2]];
  always @(posedge clk) if (dccm_wr_en) mem[dccm_addr[9:2]] <= dccm_wdata;

  atomrvcore_dccm_arbiter #(.DATAWIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_addr_i(p0_addr),
    .p0_wdata_i(p0_wdata), .p0_be_i(p0_be), .p0_gnt_o(p0_gnt),
    .p0_rvalid_o(p0_rvalid), .p0_rdata_o(p0_rdata),
    .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr),
    .p1_wdata_i(p1_wdata), .p1_be_i(p1_be), .p1_gnt_o(p1_gnt),
    .p1_rvalid_o(p1_rvalid), .p1_rdata_o(p1_rdata),
    .dccm_addr_o(dccm_addr), .dccm_wdata_o(dccm_wdata),
    .dccm_wr_en_o(dccm_wr_en), .dccm_rd_en_o(dccm_rd_en),
    .dccm_rdata_i(dccm_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (p0_rvalid === 1'b1) begin
      if (q0.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL p0_unexpected_rvalid: got 1 want 0 (cycle %0d)", cyc);
      end else begin
        e = q0.pop_front();
        chk("p0_rvalid_cycle", cyc, e.cyc);
        if (e.rd) chk("p0_rdata", p0_rdata, e.data);
      end
    end
    if (p1_rvalid === 1'b1) begin
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL p1_unexpected_rvalid: got 1 want 0 (cycle %0d)", cyc);
      end else begin
        e = q1.pop_front();
        chk("p1_rvalid_cycle", cyc, e.cyc);
        if (e.rd) chk("p1_rdata", p1_rdata, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[4]  = 32'h1111_0004;
    mem[8]  = 32'h2222_0008;
    mem[32] = 32'h1122_3344;
    mem[33] = 32'h5566_7788;
    mem[34] = 32'hCAFE_F00D;

    rst_n = 1'b0;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h10;
    p0_wdata = 32'h0; p0_be = 4'h0;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h20;
    p1_wdata = 32'h0; p1_be = 4'h0;

    // Reset held with both ports requesting.
    repeat (3) begin
      @(negedge clk);
      chk("reset_ctl", 32'({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid,
                            dccm_rd_en, dccm_wr_en}), 32'h0);
      chk("reset_addr", dccm_addr, 32'h0);
      chk("reset_wdata", dccm_wdata, 32'h0);
      chk("reset_rdata0", p0_rdata, 32'h0);
      chk("reset_rdata1", p1_rdata, 32'h0);
    end
    step();
    rst_n = 1'b1;

    // Contention: grants alternate starting with port 0.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("arb_gnt", 32'({p1_gnt, p0_gnt}), (i % 2 == 1) ? 32'h2 : 32'h1);
      chk("arb_rd_en", 32'(dccm_rd_en), 32'h1);
      if (i % 2 == 0) q0.push_back('{1'b1, 32'h1111_0004, cyc + 1});
      else            q1.push_back('{1'b1, 32'h2222_0008, cyc + 1});
      step();
    end

    // Full write then read of the same word.
    p1_req = 1'b0;
    p0_we = 1'b1; p0_addr = 32'h40; p0_wdata = 32'hDEAD_BEEF; p0_be = 4'hF;
    @(negedge clk);
    chk("fw_gnt", 32'({p1_gnt, p0_gnt}), 32'h1);
    chk("fw_en", 32'({dccm_rd_en, dccm_wr_en}), 32'h1);
    chk("fw_addr", dccm_addr, 32'h40);
    chk("fw_wdata", dccm_wdata, 32'hDEAD_BEEF);
    q0.push_back('{1'b0, 32'h0, cyc + 1});
    step();
    p0_we = 1'b0; p0_addr = 32'h43; p0_be = 4'h0;
    @(negedge clk);
    chk("fr_gnt", 32'(p0_gnt), 32'h1);
    chk("fr_addr", dccm_addr, 32'h40);
    q0.push_back('{1'b1, 32'hDEAD_BEEF, cyc + 1});
    step();
    p0_req = 1'b0;
    @(negedge clk);
    chk("idle_en", 32'({dccm_rd_en, dccm_wr_en}), 32'h0);
    chk("idle_addr", dccm_addr, 32'h0);

    // Partial write from port 1, port 0 waiting behind it.
    step();
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h80;
    p1_wdata = 32'h0000_AB00; p1_be = 4'b0010;
    @(negedge clk);
    chk("pw_gnt", 32'({p1_gnt, p0_gnt}), 32'h2);
    chk("pw_rd", 32'({dccm_rd_en, dccm_wr_en}), 32'h2);
    chk("pw_rd_addr", dccm_addr, 32'h80);
    q1.push_back('{1'b0, 32'h0, cyc + 2});
    step();
    p1_req = 1'b0;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h80; p0_be = 4'h0;
    @(negedge clk);
    chk("rmw_gnt", 32'({p1_gnt, p0_gnt}), 32'h0);
    chk("rmw_wr", 32'({dccm_rd_en, dccm_wr_en}), 32'h1);
    chk("rmw_addr", dccm_addr, 32'h80);
    chk("rmw_wdata", dccm_wdata, 32'h1122_AB44);
    step();
    @(negedge clk);
    chk("raw_gnt", 32'({p1_gnt, p0_gnt}), 32'h1);
    q0.push_back('{1'b1, 32'h1122_AB44, cyc + 1});

    // Zero-enable write: acked, no DCCM access.
    step();
    p0_we = 1'b1; p0_addr = 32'h84; p0_wdata = 32'hFFFF_FFFF; p0_be = 4'h0;
    @(negedge clk);
    chk("zw_gnt", 32'(p0_gnt), 32'h1);
    chk("zw_en", 32'({dccm_rd_en, dccm_wr_en}), 32'h0);
    q0.push_back('{1'b0, 32'h0, cyc + 1});
    step();
    p0_we = 1'b0;
    @(negedge clk);
    chk("zr_gnt", 32'(p0_gnt), 32'h1);
    q0.push_back('{1'b1, 32'h5566_7788, cyc + 1});

    // Reset during RMW_WR: write and ack are both dropped.
    step();
    p0_req = 1'b0;
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h88;
    p1_wdata = 32'h0000_00AA; p1_be = 4'b0001;
    @(negedge clk);
    chk("mr_gnt", 32'({p1_gnt, p0_gnt}), 32'h2);
    step();
    p1_req = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_en", 32'({dccm_rd_en, dccm_wr_en}), 32'h0);
    step();
    rst_n = 1'b1;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h88; p0_be = 4'h0;
    @(negedge clk);
    chk("mr_rv1", 32'(p1_rvalid), 32'h0);
    chk("mr_rd_gnt", 32'(p0_gnt), 32'h1);
    q0.push_back('{1'b1, 32'hCAFE_F00D, cyc + 1});
    step();
    p0_req = 1'b0;

    repeat (3) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'h0);
    chk("q1_drained", 32'(q1.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/atomrvcore_dccm_arbiter.md
# atomrvcore_dccm_arbiter

Two-port arbiter and sequencer in front of the single-port data CCM. It shares the DCCM between the core load/store unit (port 0) and a DMA/debug master (port 1) using round-robin arbitration. It converts sub-word stores (byte/halfword enables) into a two-cycle read-modify-write, because the DCCM only performs full-word writes. It sits between the LSU/DMA interconnect and the DCCM instance, and drives the DCCM address, data and enable pins directly.

## Interface
- DATAWIDTH, 32, data and address width; byte-enable width is DATAWIDTH/8.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  reset, synchronous, active-low.
- p0_req_i, p1_req_i  input  1  request valid, per port.
- p0_we_i, p1_we_i  input  1  1 = write, 0 = read.
- p0_addr_i, p1_addr_i  input  DATAWIDTH  byte address; bits [1:0] are ignored.
- p0_wdata_i, p1_wdata_i  input  DATAWIDTH  write data, byte-lane aligned.
- p0_be_i, p1_be_i  input  DATAWIDTH/8  write byte enables; ignored for reads.
- p0_gnt_o, p1_gnt_o  output  1  request accepted this cycle (combinational).
- p0_rvalid_o, p1_rvalid_o  output  1  one-cycle response pulse (read data or write ack).
- p0_rdata_o, p1_rdata_o  output  DATAWIDTH  registered read data; valid only with rvalid.
- dccm_addr_o  output  DATAWIDTH  word address to DCCM, {addr[31:2],2'b00}.
- dccm_wdata_o  output  DATAWIDTH  write data to DCCM.
- dccm_wr_en_o  output  1  DCCM write enable.
- dccm_rd_en_o  output  1  DCCM read enable.
- dccm_rdata_i  input  DATAWIDTH  DCCM read data; combinational from dccm_addr_o.

## Operation
- FSM states: IDLE and RMW_WR.
- Arbitration in IDLE:
  - If exactly one port requests, that port is granted.
  - If both request, the port selected by prio_q is granted.
  - After any grant, prio_q is set to the other port.
  - prio_q resets to 0 (port 0 favoured).
- Read grant: dccm_rd_en_o=1, dccm_addr_o = word address. dccm_rdata_i is captured into that port's rdata register.
- Full write (be all ones): dccm_wr_en_o=1 and dccm_wdata_o=wdata in the grant cycle.
- Zero-enable write (be=0): the request is granted and acked. No DCCM access occurs (both enables stay 0).
- Partial write (be neither 0 nor all ones):
  - Grant cycle: dccm_rd_en_o=1. Capture the old word, address, wdata, be and port id. Next state is RMW_WR.
  - RMW_WR cycle: drive dccm_addr_o from the captured address and dccm_wr_en_o=1. dccm_wdata_o byte i = be[i] ? wdata byte i : old byte i. No grants are issued. Return to IDLE.
- Response: the granted port sees exactly one rvalid pulse per accepted request. The other port's rvalid stays 0.
- Idle outputs: when no access is active, dccm_* enables are 0 and dccm_addr_o/dccm_wdata_o are 0.
- Only one DCCM operation per cycle. wr_en and rd_en are never both 1.

## Timing
- Reset values: all gnt_o, rvalid_o and dccm enables are 0. rdata_o, dccm_addr_o and dccm_wdata_o are 0. State is IDLE and prio_q is 0.
- Reads, full writes and zero-enable writes:
  - Grant in cycle N; rvalid in cycle N+1.
  - Back-to-back accesses sustain one per cycle.
- Partial write:
  - Grant in N, DCCM write in N+1, rvalid in N+2.
  - The next grant can occur no earlier than N+2.
- gnt_o is combinational from req_i and state.
  - A requester holds req and its payload until it sees gnt_o.
  - Payload is sampled only in the grant cycle.
- Read after partial write to the same word: a read granted in N+2 returns the merged word.
- Reset asserted in RMW_WR: the write is suppressed. State returns to IDLE with no rvalid. A pending rvalid is dropped.
- A request deasserted without a grant is not an error and leaves no state behind.

## Test plan
- Reset: hold rst_ni=0 for 3 cycles with both ports requesting. Required: all outputs 0 and no DCCM enable. After release, port 0 is granted first.
- Contention: both ports issue reads continuously. Required: grants alternate p0, p1, p0, p1. Each rvalid arrives 1 cycle after its grant, on the correct port.
- Full write then read: p0 writes 0xDEADBEEF to address 0x40 with be=4'hF, then reads 0x43. Required: dccm_wr_en_o in the grant cycle, an ack the next cycle, and read data 0xDEADBEEF.
- Partial write: memory word at 0x80 = 0x11223344. p1 writes 0x0000AB00 with be=4'b0010. Required:
  - rd_en in N, wr_en with 0x1122AB44 in N+1, rvalid in N+2.
  - A p0 request held during N+1 is granted in N+2.
- Zero-enable write: p0 writes with be=0. Required: gnt, no DCCM enable, rvalid the next cycle, memory unchanged.
- Reset mid-RMW: assert rst_ni=0 during RMW_WR. Required: dccm_wr_en_o=0, no rvalid, and the target word unchanged.
